// File: rtl/serial_byte_tx.sv
// serial_byte_tx
//
// Byte-to-serial transmitter feeding a bit-serial receiver. A producer loads
// bytes into a one-entry holding register; once the receiver reports ready
// on status_in the byte moves to a shift register and goes out LSB-first.
// Each bit is qualified by a write strobe held high for HIGH_CYCLES clocks
// and then low for LOW_CYCLES clocks, with the data bit stable throughout.
//
// Optional feature: define SERIAL_TX_PARITY_EN to append a ninth, even-parity
// bit (XOR of the eight data bits) after bit 7. Without it exactly eight bits
// are sent and no parity logic exists.
//
// Parameters:
//   HIGH_CYCLES  clocks write_out is high per bit (>= 1)
//   LOW_CYCLES   clocks write_out is low after each bit (>= 1)
//
// Ports:
//   clock_1MHz  in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   byte_in     in   byte to transmit
//   enqueue_in  in   load request, accepted while ready_out is 1
//   ready_out   out  holding register empty
//   status_in   in   receiver ready (same clock domain)
//   data_out    out  serial data bit
//   write_out   out  bit strobe to the receiver
//   busy_out    out  byte transmission in progress
//   done_out    out  one-cycle pulse when a byte completes

module serial_byte_tx #(
  parameter int HIGH_CYCLES = 10,
  parameter int LOW_CYCLES  = 10
) (
  input  logic       clock_1MHz,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       enqueue_in,
  output logic       ready_out,
  input  logic       status_in,
  output logic       data_out,
  output logic       write_out,
  output logic       busy_out,
  output logic       done_out
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int PW         = $clog2(MAX_CYCLES + 1);

  localparam logic [PW-1:0] HI_LAST  = PW'(HIGH_CYCLES - 1);
  localparam logic [PW-1:0] LO_LAST  = PW'(LOW_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT = 4'(NBITS - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] STROBE_HI = 2'd1;
  localparam logic [1:0] STROBE_LO = 2'd2;
  localparam logic [1:0] REARM     = 2'd3;

  logic [1:0]       state;
  logic [7:0]       hold_reg;
  logic             hold_valid;
  logic [NBITS-1:0] shift_reg;
  logic [NBITS-1:0] load_word;
  logic [3:0]       bit_cnt;
  logic [PW-1:0]    phase_cnt;
  logic             armed;
  logic             start;

  // Word copied into the shift register at the start of a byte. With parity
  // enabled the parity bit sits above bit 7 so it naturally shifts out last.
`ifdef SERIAL_TX_PARITY_EN
  assign load_word = {^hold_reg, hold_reg};
`else
  assign load_word = hold_reg;
`endif

  assign ready_out = !hold_valid;

  // A byte may only start from IDLE once the receiver has cycled status low
  // since the previous byte (armed) and now reports ready again.
  assign start = (state == IDLE) && hold_valid && armed && status_in;

  // Holding register, shift path and strobe FSM. Every output is driven from
  // a flop so the receiver never sees a combinational path from our inputs.
  // The holding register is freed by a start and may be refilled on any later
  // edge, so the next byte can be queued while the current one is shifting.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      phase_cnt  <= '0;
      armed      <= 1'b1;
      data_out   <= 1'b0;
      write_out  <= 1'b0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
    end else begin
      done_out <= 1'b0;

      if (start) begin
        hold_valid <= 1'b0;
      end else if (enqueue_in && !hold_valid) begin
        hold_reg   <= byte_in;
        hold_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= load_word;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            data_out  <= load_word[0];
            write_out <= 1'b1;
            busy_out  <= 1'b1;
            state     <= STROBE_HI;
          end
        end

        STROBE_HI: begin
          if (phase_cnt == HI_LAST) begin
            phase_cnt <= '0;
            write_out <= 1'b0;
            state     <= STROBE_LO;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        // data_out is left untouched here so the bit stays valid for the
        // whole high+low window; it only changes when the next bit begins.
        STROBE_LO: begin
          if (phase_cnt == LO_LAST) begin
            phase_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              done_out <= 1'b1;
              busy_out <= 1'b0;
              data_out <= 1'b0;
              armed    <= 1'b0;
              state    <= REARM;
            end else begin
              shift_reg <= {1'b0, shift_reg[NBITS-1:1]};
              data_out  <= shift_reg[1];
              write_out <= 1'b1;
              bit_cnt   <= bit_cnt + 1'b1;
              state     <= STROBE_HI;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        // The receiver holds status high until it has consumed a byte; wait
        // for it to drop so a queued byte cannot start ahead of that.
        REARM: begin
          if (!status_in) begin
            armed <= 1'b1;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_tx.sv
// tb_serial_byte_tx
//
// Directed self-checking bench for serial_byte_tx with default timing
// (10 clocks high, 10 clocks low per bit). Inputs change and outputs are
// sampled 1 ns after each rising edge. Define SERIAL_TX_PARITY_EN on both
// the RTL and this bench to also exercise the ninth parity bit.

module tb_serial_byte_tx;

  localparam int HI_CYC = 10;
  localparam int LO_CYC = 10;
  localparam int BIT_CYC = HI_CYC + LO_CYC;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clock;
  logic       rst;
  logic [7:0] byte_in;
  logic       enqueue_in;
  logic       ready_out;
  logic       status_in;
  logic       data_out;
  logic       write_out;
  logic       busy_out;
  logic       done_out;

  int total_checks;
  int bad_checks;

  serial_byte_tx #(
    .HIGH_CYCLES(HI_CYC),
    .LOW_CYCLES (LO_CYC)
  ) dut (
    .clock_1MHz(clock),
    .rst       (rst),
    .byte_in   (byte_in),
    .enqueue_in(enqueue_in),
    .ready_out (ready_out),
    .status_in (status_in),
    .data_out  (data_out),
    .write_out (write_out),
    .busy_out  (busy_out),
    .done_out  (done_out)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic enq, input logic status);
    byte_in    = b;
    enqueue_in = enq;
    status_in  = status;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // Called at the sample point just after the first strobe rose. Follows the
  // whole byte, counting high/low cycles and data changes per bit, then checks
  // the done pulse. Optionally queues another byte early in bit 2.
  task automatic checkByte(input string name, input logic [8:0] bits, input int nbits,
                           input logic do_enq, input logic [7:0] enq_byte);
    int hi_cnt;
    int lo_cnt;
    int data_err;
    for (int b = 0; b < nbits; b++) begin
      hi_cnt = 0;
      lo_cnt = 0;
      data_err = 0;
      for (int c = 0; c < BIT_CYC; c++) begin
        if (c < HI_CYC) hi_cnt += int'(write_out);
        else lo_cnt += int'(!write_out);
        if (data_out !== bits[b]) data_err++;
        if (do_enq && b == 2 && c == 0) begin
          byte_in = enq_byte;
          enqueue_in = 1'b1;
        end
        if (b == 2 && c == 1) enqueue_in = 1'b0;
        stepCycle();
      end
      checkOutput($sformatf("%s bit%0d high cycles", name, b), hi_cnt, HI_CYC);
      checkOutput($sformatf("%s bit%0d low cycles", name, b), lo_cnt, LO_CYC);
      checkOutput($sformatf("%s bit%0d data errors", name, b), data_err, 0);
    end
    checkOutput({name, " done pulse"}, done_out, 1'b1);
    checkOutput({name, " busy at done"}, busy_out, 1'b0);
    checkOutput({name, " write at done"}, write_out, 1'b0);
    stepCycle();
    checkOutput({name, " done one cycle"}, done_out, 1'b0);
  endtask

  // Lets the REARM state see status low for one edge, then raises it again.
  task automatic rearm();
    status_in = 1'b0;
    stepCycle();
    status_in = 1'b1;
  endtask

  int strobe_cnt;

  initial begin
    total_checks = 0;
    bad_checks = 0;
    rst = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0);

    // Reset held for three cycles.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst ready", ready_out, 1'b1);
    checkOutput("rst write", write_out, 1'b0);
    checkOutput("rst data", data_out, 1'b0);
    checkOutput("rst busy", busy_out, 1'b0);
    checkOutput("rst done", done_out, 1'b0);
    rst = 1'b1;
    stepCycle();

    // 8'hAA with the receiver already ready.
    applyStimulus(8'hAA, 1'b1, 1'b1);
    stepCycle();
    checkOutput("AA ready after enqueue", ready_out, 1'b0);
    checkOutput("AA no strobe yet", write_out, 1'b0);
    enqueue_in = 1'b0;
    stepCycle();
    checkOutput("AA first strobe", write_out, 1'b1);
    checkOutput("AA ready after start", ready_out, 1'b1);
    checkOutput("AA busy", busy_out, 1'b1);
    checkByte("AA", {1'b0, 8'hAA}, 8, 1'b0, 8'h00);

    // 8'h5A while status is low: nothing moves until status rises.
    applyStimulus(8'h5A, 1'b1, 1'b0);
    stepCycle();
    enqueue_in = 1'b0;
    strobe_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      strobe_cnt += int'(write_out);
      stepCycle();
    end
    checkOutput("5A no strobe status low", strobe_cnt, 0);
    checkOutput("5A ready held low", ready_out, 1'b0);
    status_in = 1'b1;
    stepCycle();
    checkOutput("5A strobe after status", write_out, 1'b1);
    checkOutput("5A first bit", data_out, 1'b0);
    checkByte("5A", {1'b0, 8'h5A}, 8, 1'b0, 8'h00);

    // 8'h3C, with 8'hC3 queued during it; C3 must wait for a status cycle.
    rearm();
    applyStimulus(8'h3C, 1'b1, 1'b1);
    stepCycle();
    enqueue_in = 1'b0;
    stepCycle();
    checkOutput("3C first strobe", write_out, 1'b1);
    checkByte("3C", {1'b0, 8'h3C}, 8, 1'b1, 8'hC3);
    checkOutput("C3 still held", ready_out, 1'b0);
    strobe_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      strobe_cnt += int'(write_out);
      stepCycle();
    end
    checkOutput("C3 waits for status drop", strobe_cnt, 0);
    rearm();
    stepCycle();
    checkOutput("C3 first strobe", write_out, 1'b1);
    checkOutput("C3 first bit", data_out, 1'b1);
    checkByte("C3", {1'b0, 8'hC3}, 8, 1'b0, 8'h00);

    // 8'hFF aborted by reset during bit 3; a queued 8'h81 is lost as well.
    rearm();
    applyStimulus(8'hFF, 1'b1, 1'b1);
    stepCycle();
    enqueue_in = 1'b0;
    stepCycle();
    checkOutput("FF first strobe", write_out, 1'b1);
    applyStimulus(8'h81, 1'b1, 1'b1);
    stepCycle();
    enqueue_in = 1'b0;
    checkOutput("81 held", ready_out, 1'b0);
    repeat (64) stepCycle();
    checkOutput("FF bit3 strobe high", write_out, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort write", write_out, 1'b0);
    checkOutput("abort busy", busy_out, 1'b0);
    checkOutput("abort ready", ready_out, 1'b1);
    @(negedge clock);
    rst = 1'b1;
    strobe_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      stepCycle();
      strobe_cnt += int'(write_out);
    end
    checkOutput("no strobes after abort", strobe_cnt, 0);
    checkOutput("ready after abort", ready_out, 1'b1);
    checkOutput("idle after abort", busy_out, 1'b0);

`ifdef SERIAL_TX_PARITY_EN
    // Parity: 8'h07 has three ones (parity 1), 8'h03 has two (parity 0).
    applyStimulus(8'h07, 1'b1, 1'b1);
    stepCycle();
    enqueue_in = 1'b0;
    stepCycle();
    checkOutput("07 first strobe", write_out, 1'b1);
    checkByte("P07", 9'b1_0000_0111, NB, 1'b0, 8'h00);
    rearm();
    applyStimulus(8'h03, 1'b1, 1'b1);
    stepCycle();
    enqueue_in = 1'b0;
    stepCycle();
    checkOutput("03 first strobe", write_out, 1'b1);
    checkByte("P03", 9'b0_0000_0011, NB, 1'b0, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  // Watchdog so the run always ends even if the DUT wedges a wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
